uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver for the SoC: samples the board RX pin, decodes 8N1 frames and buffers received bytes in a small FIFO. Its consumer is the `machine` core's UART peripheral register, which reads bytes through a valid/ready port. It is the receive-side counterpart of the existing `uart_tx` output. It runs in the PLL clock domain, and its reset is released once the PLL reports `locked`.

## Interface

Parameters
- `CLK_HZ`, default 24000000: system clock frequency in Hz.
- `BAUD`, default 115200: line bit rate.
- `DEPTH`, default 4: FIFO depth in bytes. Must be a power of 2, at least 2.
- Derived: `DIV = CLK_HZ / BAUD`, truncating integer division; 208 at the defaults. `DIV` must be at least 4.

Ports
- `clk`, input, 1 bit: system clock. All logic is on the rising edge.
- `rst_n`, input, 1 bit: asynchronous reset, active-low.
- `rx`, input, 1 bit: serial line, asynchronous to `clk`, idle high.
- `rd_data`, output, 8 bits: byte at the FIFO head. Valid only while `rd_valid` is high.
- `rd_valid`, output, 1 bit: FIFO is not empty.
- `rd_ready`, input, 1 bit: consumer accepts `rd_data`. A byte is popped on any cycle where `rd_valid && rd_ready`.
- `frame_err`, output, 1 bit: one-cycle pulse when a received stop bit is 0.
- `overrun`, output, 1 bit: sticky flag, set when a good byte is dropped because the FIFO is full.
- `err_clr`, input, 1 bit: synchronous clear of `overrun`.

## Operation

- **Input conditioning.** `rx` passes through a 2-flop synchronizer that resets to 1, giving `rx_s`.
- **Edge detection.** A falling edge is registered `rx_s` = 1 on the previous cycle and 0 on the current cycle.
- **State machine.** States are IDLE, START, DATA and STOP. A single down-counter `cnt` is used, with width ceil(log2(DIV)) + 1.
  - IDLE: on a falling edge, load `cnt = DIV/2 - 1` and go to START.
  - START: when `cnt == 0`, sample `rx_s`.
    - Sample is 1: treat as a glitch and return to IDLE. No flags change.
    - Sample is 0: load `cnt = DIV - 1`, clear the bit index, go to DATA.
  - DATA: each time `cnt == 0`, sample `rx_s` into the shift register, LSB first, and reload `cnt = DIV - 1`. After the 8th sample, go to STOP.
  - STOP: when `cnt == 0`, sample the stop bit.
    - Stop bit is 1: push the byte, then go to IDLE.
    - Stop bit is 0: pulse `frame_err` for one cycle, discard the byte, then go to IDLE.
- **Recovery after a bad stop bit.** A new frame requires a fresh 1-to-0 transition. A line held low (break) therefore produces exactly one `frame_err` and no further frames.
- **FIFO.** Circular buffer of `DEPTH` entries with read and write pointers one bit wider than the address, used for full/empty detection.
  - `rd_data` is the head entry, read combinationally.
  - Push and pop on the same cycle while the FIFO is not empty: both happen and the occupancy is unchanged.
  - Push while full, with a pop on the same cycle: the push is accepted. The slot freed by the pop is used.
  - Push while full, with no pop: the byte is dropped and `overrun` is set. FIFO contents are unchanged.
  - If `err_clr` and a new overrun occur on the same cycle, the set wins.
- **Reset values.** All outputs and internal state are reset as follows:
  - `rd_valid` = 0, `rd_data` = 0, `frame_err` = 0, `overrun` = 0.
  - State is IDLE and both FIFO pointers are 0.
  - Both synchronizer flops are 1.
- **Reset mid-frame.** Asserting reset during a frame abandons it. After release, the receiver waits in IDLE for the next falling edge.

## Timing

- Let T0 be the cycle in which `rx_s` is first sampled low, which is 2 cycles after the pin falls.
- Start sample: T0 + DIV/2.
- Data bit k (k = 0..7): T0 + DIV/2 + (k+1)·DIV.
- Stop sample: T0 + DIV/2 + 9·DIV.
- Push and `frame_err` are registered on the stop-sample edge. `rd_valid` rises in the following cycle.
- Back-to-back frames: the falling edge of the next start bit can be detected any cycle after the stop sample. There is no dead time beyond the state-machine return to IDLE.
- Baud tolerance: with DIV ≥ 16, mid-bit sampling tolerates about ±4% rate error.
- Pop latency: the next FIFO entry appears on `rd_data` in the cycle after the pop. `rd_valid` falls in that cycle if the FIFO is now empty.

## Test plan

All scenarios use CLK_HZ=1600000, BAUD=100000, so DIV=16, and DEPTH=4.

- **Single byte.** Send 0xA5 with `rd_ready` = 0. Required: `rd_valid` rises exactly T0 + 153 cycles; `rd_data` = 0xA5; `frame_err` never pulses. Then pulse `rd_ready` for one cycle: `rd_valid` = 0 on the next cycle.
- **Burst.** Send 0x00, 0xFF, 0x55 back-to-back with `rd_ready` held at 1. Required: three pops, in order, with the same values; `overrun` stays 0.
- **Overrun.** Send 5 bytes, 0x01 through 0x05, with `rd_ready` = 0. Required: FIFO holds 0x01..0x04; `overrun` = 1. Assert `err_clr` for one cycle: `overrun` = 0.
- **Glitch and framing error.**
  - A 4-cycle low pulse on `rx`: no state change beyond returning to IDLE, no flags.
  - A frame carrying 0x3C with stop bit 0: exactly one `frame_err` pulse, FIFO unchanged.
  - Holding `rx` low for 40 bit times: exactly one `frame_err` pulse.
- **Full with simultaneous pop.** Fill the FIFO to 4 entries, then assert `rd_ready` in the same cycle the 5th byte (0x77) is pushed. Required: `overrun` = 0; occupancy stays 4; 0x77 is the last entry read out.
- **Reset mid-frame.** Assert `rst_n` = 0 during bit 3 of a frame. Required: all outputs read their reset values while reset is held. After release, a following 0x5A frame is received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// Byte read port of the UART receiver: head-of-FIFO data with valid/ready handshake.
`timescale 1ns/1ps
interface uart_rx_if;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;

  modport master (output rd_data, output rd_valid, input rd_ready);
  modport slave  (input rd_data, input rd_valid, output rd_ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 serial receiver: synchronizes the RX pin, samples mid-bit with a down-counter
// and buffers good bytes in a small circular FIFO read through a valid/ready port.
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLK_HZ = 24000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       err_clr,
  output logic       frame_err,
  output logic       overrun,
  uart_rx_if.master  rd
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV) + 1;
  localparam int AW  = $clog2(DEPTH);

  localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  logic          sync_meta_r;
  logic          rx_sync_r;
  logic          rx_prev_r;
  logic          fall_s;

  state_t        state_r, state_nxt;
  logic [CW-1:0] cnt_r, cnt_nxt;
  logic [2:0]    bit_idx_r, bit_idx_nxt;
  logic [7:0]    shift_r, shift_nxt;
  logic          push_s;
  logic          ferr_s;

  logic [7:0]    mem_r [DEPTH];
  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  logic          empty_s;
  logic          full_s;
  logic          pop_s;
  logic          wr_en_s;
  logic          drop_s;

  // Two-flop synchronizer plus one delay stage for falling-edge detection; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta_r <= 1'b1;
      rx_sync_r   <= 1'b1;
      rx_prev_r   <= 1'b1;
    end else begin
      sync_meta_r <= rx;
      rx_sync_r   <= sync_meta_r;
      rx_prev_r   <= rx_sync_r;
    end
  end

  assign fall_s = rx_prev_r & ~rx_sync_r;

  // Receiver state, bit counter and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      frame_err <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      cnt_r     <= cnt_nxt;
      bit_idx_r <= bit_idx_nxt;
      shift_r   <= shift_nxt;
      frame_err <= ferr_s;
    end
  end

  // Next-state logic; every sample point is where the down-counter reaches zero.
  always_comb begin
    state_nxt   = state_r;
    cnt_nxt     = cnt_r;
    bit_idx_nxt = bit_idx_r;
    shift_nxt   = shift_r;
    push_s      = 1'b0;
    ferr_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (fall_s) begin
          cnt_nxt   = HALF_LOAD;
          state_nxt = ST_START;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_r == CNT_ZERO) begin
          if (rx_sync_r) begin
            state_nxt = ST_IDLE;
          end else begin
            cnt_nxt     = FULL_LOAD;
            bit_idx_nxt = 3'd0;
            state_nxt   = ST_DATA;
          end
        end else begin
          cnt_nxt = cnt_r - CNT_ONE;
        end
      end
      ST_DATA: begin
        if (cnt_r == CNT_ZERO) begin
          shift_nxt   = {rx_sync_r, shift_r[7:1]};
          cnt_nxt     = FULL_LOAD;
          bit_idx_nxt = bit_idx_r + 3'd1;
          if (bit_idx_r == 3'd7) begin
            state_nxt = ST_STOP;
          end else begin
            state_nxt = ST_DATA;
          end
        end else begin
          cnt_nxt = cnt_r - CNT_ONE;
        end
      end
      ST_STOP: begin
        if (cnt_r == CNT_ZERO) begin
          if (rx_sync_r) begin
            push_s = 1'b1;
          end else begin
            ferr_s = 1'b1;
          end
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_s   = !empty_s && rd.rd_ready;
  assign wr_en_s = push_s && (!full_s || pop_s);
  assign drop_s  = push_s && full_s && !pop_s;

  assign rd.rd_valid = !empty_s;
  assign rd.rd_data  = mem_r[rd_ptr_r[AW-1:0]];

  // FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r <= {(AW + 1){1'b0}};
      rd_ptr_r <= {(AW + 1){1'b0}};
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= shift_r;
        wr_ptr_r                <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Sticky overrun flag; a new drop outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (drop_s) begin
      overrun <= 1'b1;
    end else if (err_clr) begin
      overrun <= 1'b0;
    end else begin
      overrun <= overrun;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIV=16, DEPTH=4 with hand-computed expectations.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int DIV = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic rx;
  logic err_clr;
  logic frame_err;
  logic overrun;

  uart_rx_if rd_if ();

  uart_rx #(
    .CLK_HZ (1600000),
    .BAUD   (100000),
    .DEPTH  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .err_clr   (err_clr),
    .frame_err (frame_err),
    .overrun   (overrun),
    .rd        (rd_if.master)
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int ferr_cnt = 0;
  int cyc      = 0;
  int fall_cyc = 0;
  int rise_cyc = 0;
  int ferr_base;
  logic rv_q = 1'b0;
  logic [7:0] pop_q [$];

  // Free-running cycle count, frame_err pulse count and log of popped bytes.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (rd_if.rd_valid && rd_if.rd_ready) pop_q.push_back(rd_if.rd_data);
  end

  // Cycle stamp of each rd_valid rising edge.
  always @(negedge clk) begin
    if (rd_if.rd_valid && !rv_q) rise_cyc <= cyc;
    rv_q <= rd_if.rd_valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // All line-driving tasks start and end #1 after a rising edge.
  task automatic send_bit(input logic b);
    rx = b;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    fall_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    rd_if.rd_ready = 1'b1;
    @(posedge clk);
    #1;
    rd_if.rd_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    rx = 1'b1;
    err_clr = 1'b0;
    rd_if.rd_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("rst_rd_valid", {31'd0, rd_if.rd_valid}, 32'd0);
    check_eq("rst_rd_data", {24'd0, rd_if.rd_data}, 32'd0);
    check_eq("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check_eq("rst_overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    idle(10);

    // Single byte and latency
    send_frame(8'hA5, 1'b1);
    idle(10);
    check_eq("single_latency", rise_cyc - fall_cyc, 32'd155);
    check_eq("single_valid", {31'd0, rd_if.rd_valid}, 32'd1);
    check_eq("single_data", {24'd0, rd_if.rd_data}, 32'hA5);
    check_eq("single_no_ferr", ferr_cnt, 32'd0);
    pop_one();
    check_eq("single_pop_empty", {31'd0, rd_if.rd_valid}, 32'd0);
    pop_q.delete();

    // Back-to-back burst with consumer always ready
    rd_if.rd_ready = 1'b1;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    idle(20);
    rd_if.rd_ready = 1'b0;
    check_eq("burst_count", pop_q.size(), 32'd3);
    if (pop_q.size() == 3) begin
      check_eq("burst_b0", {24'd0, pop_q[0]}, 32'h00);
      check_eq("burst_b1", {24'd0, pop_q[1]}, 32'hFF);
      check_eq("burst_b2", {24'd0, pop_q[2]}, 32'h55);
    end
    check_eq("burst_overrun", {31'd0, overrun}, 32'd0);
    check_eq("burst_empty", {31'd0, rd_if.rd_valid}, 32'd0);

    // Overrun: five bytes into a four-entry FIFO
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    idle(10);
    check_eq("ovr_set", {31'd0, overrun}, 32'd1);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check_eq("ovr_clr", {31'd0, overrun}, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      check_eq("ovr_valid", {31'd0, rd_if.rd_valid}, 32'd1);
      check_eq("ovr_data", {24'd0, rd_if.rd_data}, i);
      pop_one();
    end
    check_eq("ovr_drained", {31'd0, rd_if.rd_valid}, 32'd0);

    // Short glitch is rejected at the start sample
    ferr_base = ferr_cnt;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(200);
    check_eq("glitch_ferr", ferr_cnt - ferr_base, 32'd0);
    check_eq("glitch_empty", {31'd0, rd_if.rd_valid}, 32'd0);

    // Bad stop bit
    ferr_base = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    idle(40);
    check_eq("stop0_ferr", ferr_cnt - ferr_base, 32'd1);
    check_eq("stop0_empty", {31'd0, rd_if.rd_valid}, 32'd0);

    // Break: line low for 40 bit times
    ferr_base = ferr_cnt;
    rx = 1'b0;
    repeat (40 * DIV) @(posedge clk);
    #1;
    idle(40);
    check_eq("break_ferr", ferr_cnt - ferr_base, 32'd1);
    check_eq("break_empty", {31'd0, rd_if.rd_valid}, 32'd0);
    check_eq("break_overrun", {31'd0, overrun}, 32'd0);

    // Full FIFO with a pop in the very cycle the fifth byte is pushed
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    pop_q.delete();
    fork
      send_frame(8'h77, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1;
        rd_if.rd_ready = 1'b1;
        @(posedge clk);
        #1;
        rd_if.rd_ready = 1'b0;
      end
    join
    idle(10);
    check_eq("fullpop_overrun", {31'd0, overrun}, 32'd0);
    check_eq("fullpop_popped", pop_q.size(), 32'd1);
    check_eq("fullpop_d0", {24'd0, rd_if.rd_data}, 32'h22);
    pop_one();
    check_eq("fullpop_d1", {24'd0, rd_if.rd_data}, 32'h33);
    pop_one();
    check_eq("fullpop_d2", {24'd0, rd_if.rd_data}, 32'h44);
    pop_one();
    check_eq("fullpop_last", {24'd0, rd_if.rd_data}, 32'h77);
    check_eq("fullpop_valid", {31'd0, rd_if.rd_valid}, 32'd1);
    pop_one();
    check_eq("fullpop_empty", {31'd0, rd_if.rd_valid}, 32'd0);

    // Reset during bit 3 with a byte already buffered
    send_frame(8'h99, 1'b1);
    idle(5);
    check_eq("prerst_valid", {31'd0, rd_if.rd_valid}, 32'd1);
    fork
      send_frame(8'hC3, 1'b1);
      begin
        repeat (DIV + 3 * DIV + 8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("midrst_valid", {31'd0, rd_if.rd_valid}, 32'd0);
        check_eq("midrst_data", {24'd0, rd_if.rd_data}, 32'd0);
        check_eq("midrst_ferr", {31'd0, frame_err}, 32'd0);
        check_eq("midrst_overrun", {31'd0, overrun}, 32'd0);
      end
    join
    idle(20);
    rst_n = 1'b1;
    idle(20);
    ferr_base = ferr_cnt;
    send_frame(8'h5A, 1'b1);
    idle(10);
    check_eq("postrst_valid", {31'd0, rd_if.rd_valid}, 32'd1);
    check_eq("postrst_data", {24'd0, rd_if.rd_data}, 32'h5A);
    check_eq("postrst_ferr", ferr_cnt - ferr_base, 32'd0);
    pop_one();
    check_eq("postrst_empty", {31'd0, rd_if.rd_valid}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
